// File: rtl/serial_tx_device_pkg.sv
// Shared definitions for the memory-mapped 8N1 serial transmitter:
// FSM state encoding, control/status bit positions and register offsets.
package serial_tx_device_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Control/status register bit positions
    localparam int CTRL_RDY_BIT  = 0;
    localparam int CTRL_OVF_BIT  = 2;
    localparam int CTRL_BUSY_BIT = 4;
    localparam int CTRL_IE_BIT   = 8;

    // Control register sits this far above the data register
    localparam logic [31:0] CTRL_OFFSET = 32'h100;

endpackage

// File: rtl/serial_tx_device_if.sv
// Processor-bus view of the transmitter. The shared tri-state DBUS is split
// into its two directions: DBUS carries CPU write data towards the device,
// DBUS_O/DBUS_OE carry read data back; the bus buffer drives the shared wire
// from DBUS_O only while DBUS_OE is high and leaves it hi-Z otherwise.
interface serial_tx_device_if #(
    parameter int BITS = 32
);
    logic [BITS-1:0] ABUS;
    logic [BITS-1:0] DBUS;
    logic            WE;
    logic            FLUSH;
    logic [BITS-1:0] DBUS_O;
    logic            DBUS_OE;

    modport master (
        output ABUS, DBUS, WE, FLUSH,
        input  DBUS_O, DBUS_OE
    );

    modport slave (
        input  ABUS, DBUS, WE, FLUSH,
        output DBUS_O, DBUS_OE
    );
endinterface

// File: rtl/serial_tx_device_tx_fifo.sv
// tx_fifo: small synchronous FIFO holding bytes waiting to be serialised.
// A push while full is accepted when a pop happens in the same cycle.
module serial_tx_device_tx_fifo #(
    parameter int AW = 2,
    parameter int W  = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array, contents need no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/serial_tx_device.sv
// Memory-mapped 8N1 UART transmitter. CPU stores bytes to the data register,
// they queue in tx_fifo and are sent LSB-first on TXD. The control register
// exposes ready/overrun/busy and the interrupt enable.
module serial_tx_device
    import serial_tx_device_pkg::*;
#(
    parameter int              BITS         = 32,
    parameter logic [BITS-1:0] BASE         = 32'hF0000040,
    parameter int              CLKS_PER_BIT = 434,
    parameter int              FIFO_AW      = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    serial_tx_device_if.slave    bus,
    output logic                 INTR,
    output logic                 TXD,
    output logic [FIFO_AW+5:0]   DEBUG
);
    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   RELOAD    = BW'(CLKS_PER_BIT - 1);
    localparam logic [BITS-1:0] CTRL_ADDR = BASE + BITS'(CTRL_OFFSET);

    tx_state_e       state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            txd_q;
    logic            ie_q, ovf_q;

    logic            sel_data, sel_ctrl, wr_data, wr_ctrl, rd_en;
    logic            fifo_full, fifo_empty, pop, overrun, baud_done, rdy, busy;
    logic [7:0]      fifo_dout;
    logic [FIFO_AW:0] count;
    logic [BITS-1:0] ctrl_word;
    logic            unused_dbus;

    assign sel_data  = (bus.ABUS == BASE) & ~bus.FLUSH;
    assign sel_ctrl  = (bus.ABUS == CTRL_ADDR) & ~bus.FLUSH;
    assign wr_data   = bus.WE & sel_data;
    assign wr_ctrl   = bus.WE & sel_ctrl;
    assign rd_en     = ~bus.WE & (sel_data | sel_ctrl);
    assign baud_done = (baud_q == '0);
    // Pop when idle, or at the last stop-bit cycle so frames run back to back
    assign pop       = ~fifo_empty & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_done));
    assign overrun   = wr_data & fifo_full & ~pop;
    assign rdy       = ~fifo_full;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
    assign unused_dbus = ^bus.DBUS[BITS-1:9];

    serial_tx_device_tx_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (wr_data),
        .pop_i   (pop),
        .din_i   (bus.DBUS[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // Read-data mux: data register returns occupancy, control returns status
    always_comb begin
        ctrl_word                = '0;
        ctrl_word[CTRL_RDY_BIT]  = rdy;
        ctrl_word[CTRL_OVF_BIT]  = ovf_q;
        ctrl_word[CTRL_BUSY_BIT] = busy;
        ctrl_word[CTRL_IE_BIT]   = ie_q;
        bus.DBUS_OE = rd_en;
        bus.DBUS_O  = '0;
        if (rd_en && sel_data)      bus.DBUS_O = BITS'(count);
        else if (rd_en && sel_ctrl) bus.DBUS_O = ctrl_word;
    end

    // Control register: IE written directly, OVF sticky until cleared by a ctrl write
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ie_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (wr_ctrl) begin
            ie_q <= bus.DBUS[CTRL_IE_BIT];
            if (!bus.DBUS[CTRL_OVF_BIT]) ovf_q <= 1'b0;
        end else if (overrun) begin
            ovf_q <= 1'b1;
        end
    end

    // Frame FSM with baud counter, shift register and registered TXD
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_dout;
                        baud_q  <= RELOAD;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_q  <= RELOAD;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_q <= RELOAD;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift_q <= fifo_dout;
                            baud_q  <= RELOAD;
                            txd_q   <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TXD   = txd_q;
    assign INTR  = ie_q & rdy;
    assign DEBUG = {state_q, count, ovf_q, ie_q, txd_q};
endmodule

// File: tb/tb_serial_tx_device.sv
// Bench for serial_tx_device: a frame-level reference model (byte queue plus
// the 10-bit frame currently on the line) checked every cycle, a line
// receiver that decodes TXD, and directed scenarios with literal expectations.
module tb_serial_tx_device;
    import serial_tx_device_pkg::*;

    localparam int          CPB   = 4;
    localparam int          AW    = 2;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'hF0000040;
    localparam logic [31:0] CTRL  = 32'hF0000140;

    logic       CLK;
    logic       RESET;
    logic       INTR, TXD;
    logic [7:0] DEBUG;

    serial_tx_device_if #(.BITS(32)) bus ();

    serial_tx_device #(.BITS(32), .BASE(BASE), .CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .INTR  (INTR),
        .TXD   (TXD),
        .DEBUG (DEBUG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] q[$];
    bit         m_active;
    int         m_pos;
    logic [9:0] m_frame;
    bit         m_ovf, m_ie, m_valid;
    int         cyc;

    // decoded line traffic
    logic [7:0] rx_q[$];
    int         rx_t[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_txd();
        return m_active ? m_frame[m_pos / CPB] : 1'b1;
    endfunction

    task automatic model_proc();
        bit         pop;
        logic [7:0] pb;
        forever begin
            @(posedge CLK);
            cyc++;
            if (RESET) begin
                q.delete();
                m_active = 0; m_pos = 0; m_ovf = 0; m_ie = 0; m_valid = 1;
            end else if (m_valid) begin
                pop = (q.size() != 0) && (!m_active || m_pos == FRAME - 1);
                pb  = 8'h00;
                if (pop) pb = q.pop_front();
                if (!bus.FLUSH && bus.WE && bus.ABUS == BASE) begin
                    if (q.size() < DEPTH) q.push_back(bus.DBUS[7:0]);
                    else m_ovf = 1;
                end
                if (!bus.FLUSH && bus.WE && bus.ABUS == CTRL) begin
                    m_ie = bus.DBUS[8];
                    if (!bus.DBUS[2]) m_ovf = 0;
                end
                if (pop) begin
                    m_frame = {1'b1, pb, 1'b0}; m_pos = 0; m_active = 1;
                end else if (m_active) begin
                    m_pos++;
                    if (m_pos == FRAME) m_active = 0;
                end
            end
        end
    endtask

    task automatic compare_proc();
        int          n;
        bit          eoe, busy;
        logic [31:0] edata;
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                n    = q.size();
                busy = m_active || (n != 0);
                check("txd", TXD, m_txd());
                check("intr", INTR, m_ie && (n < DEPTH));
                check("debug", DEBUG[5:0], {3'(n), m_ovf, m_ie, m_txd()});
                check("idle_state", (DEBUG[7:6] == ST_IDLE), !m_active);
                eoe   = 0;
                edata = 0;
                if (!bus.FLUSH && !bus.WE && bus.ABUS == BASE) begin
                    eoe = 1; edata = n;
                end else if (!bus.FLUSH && !bus.WE && bus.ABUS == CTRL) begin
                    eoe = 1;
                    edata = (32'(m_ie) << 8) | (32'(busy) << 4) | (32'(m_ovf) << 2) | 32'(n < DEPTH);
                end
                check("dbus_oe", bus.DBUS_OE, eoe);
                if (eoe) check("dbus_rd", bus.DBUS_O, edata);
            end
        end
    endtask

    // Line receiver: start bit detected at its first cycle, bits sampled mid-bit
    task automatic rx_proc();
        bit         busy = 0;
        int         cnt = 0, t0 = 0;
        logic [7:0] b = 0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                busy = 0;
            end else if (!busy) begin
                if (TXD === 1'b0) begin busy = 1; cnt = 0; t0 = cyc; end
            end else begin
                cnt++;
                if (cnt >= CPB + 1 && cnt < 9 * CPB + 1 && (cnt - 1) % CPB == 0)
                    b[(cnt - 1) / CPB - 1] = TXD;
                if (cnt == 9 * CPB + 1) begin
                    busy = 0;
                    if (TXD === 1'b1) begin rx_q.push_back(b); rx_t.push_back(t0); end
                end
            end
        end
    endtask

    task automatic drive(input logic [31:0] a, input bit we, input bit fl, input logic [31:0] d);
        @(negedge CLK);
        #2;
        bus.ABUS = a; bus.WE = we; bus.FLUSH = fl; bus.DBUS = d;
    endtask

    task automatic go_idle();
        bus.ABUS = 0; bus.WE = 0; bus.FLUSH = 0; bus.DBUS = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, 1, 0, d);
        @(posedge CLK);
        #1 go_idle();
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 0, 0, 0);
        #1;
        check({name, "_oe"}, bus.DBUS_OE, 1);
        check(name, bus.DBUS_O, exp);
    endtask

    task automatic stimulus();
        int          bits5a[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
        logic [7:0]  exp_rx[6] = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic        e;
        int          t;
        // 1: reset
        @(negedge CLK); @(negedge CLK); #2 RESET = 0;
        rd_check("rst_ctrl", CTRL, 32'h1);
        check("rst_txd", TXD, 1);
        check("rst_intr", INTR, 0);
        rd_check("rst_data", BASE, 32'h0);
        drive(0, 0, 0, 0);
        // 2: single byte 0x5A, edge E is the write edge
        wr(BASE, 32'h5A);
        for (int k = 0; k <= 44; k++) begin
            @(negedge CLK);
            if (k == 0)       e = 1'b1;
            else if (k <= 4)  e = 1'b0;
            else if (k <= 36) e = 1'(bits5a[(k - 5) / 4]);
            else              e = 1'b1;
            check("frame5a_txd", TXD, e);
            if (k >= 39 && k <= 41) begin
                #2 bus.ABUS = CTRL; bus.WE = 0;
                #1 check("busy_tail", bus.DBUS_O, (k <= 40) ? 32'h11 : 32'h01);
            end
            if (k == 42) begin #2 go_idle(); end
        end
        // 3: overrun
        for (int i = 1; i <= 6; i++) wr(BASE, 32'(i));
        rd_check("ovr_ctrl", CTRL, 32'h14);
        // 4: interrupt enable while full
        wr(CTRL, 32'h100);
        @(negedge CLK);
        check("ie_full_intr", INTR, 0);
        check("ovf_cleared", DEBUG[2], 0);
        check("ie_set", DEBUG[1], 1);
        t = 0;
        while (INTR !== 1'b1 && t < 80) begin @(negedge CLK); t++; end
        check("intr_rise", INTR, 1);
        check("intr_count", DEBUG[5:3], 3);
        repeat (180) @(negedge CLK);
        rd_check("drain_ctrl", CTRL, 32'h101);
        check("drain_intr", INTR, 1);
        drive(0, 0, 0, 0);
        wr(CTRL, 32'h0);
        // 5: flush suppresses selects
        drive(BASE, 1, 1, 32'h77);
        #1 check("flush_wr_oe", bus.DBUS_OE, 0);
        drive(BASE, 0, 1, 0);
        #1 check("flush_rd_data_oe", bus.DBUS_OE, 0);
        drive(CTRL, 0, 1, 0);
        #1 check("flush_rd_ctrl_oe", bus.DBUS_OE, 0);
        drive(0, 0, 0, 0);
        repeat (6) begin @(negedge CLK); check("flush_txd", TXD, 1); end
        rd_check("flush_cnt", BASE, 32'h0);
        drive(0, 0, 0, 0);
        // 6: reset during data bit 3 of 0xC3 (bit3 = 0)
        wr(BASE, 32'hC3);
        for (int k = 0; k <= 18; k++) @(negedge CLK);
        check("pre_rst_bit3", TXD, 0);
        #2 RESET = 1;
        @(negedge CLK);
        check("mid_rst_txd", TXD, 1);
        check("mid_rst_count", DEBUG[5:3], 0);
        #2 RESET = 0;
        rd_check("mid_rst_ctrl", CTRL, 32'h1);
        rd_check("mid_rst_data", BASE, 32'h0);
        drive(0, 0, 0, 0);
        repeat (60) @(negedge CLK);
        // received traffic
        check("rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) check("rx_byte", rx_q[i], exp_rx[i]);
        for (int i = 1; i + 1 < 6 && i + 1 < rx_t.size(); i++)
            check("rx_gap", rx_t[i + 1] - rx_t[i], FRAME);
    endtask

    initial begin
        RESET = 1;
        go_idle();
        fork
            model_proc();
            compare_proc();
            rx_proc();
            stimulus();
            begin
                #100000;
                failures++;
                $display("FAIL global_timeout: got running expected finished at t=%0t", $time);
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
